axis_packetizer_v2: RTL

Gated AXI4-Stream packetizer, successor to the single-shot/continuous packetizer. Cuts a continuous ADC/DSP sample stream into fixed-length packets with TLAST and a start-of-packet TUSER flag. Supports a programmable packet count (finite burst or unlimited), explicit start and graceful-stop triggers, and an optional drop mode that keeps upstream flowing while idle. Sits between the sample source and the DMA/RAM writer.

---
 rtl/axis_packetizer_v2.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/axis_packetizer_v2.sv
`default_nettype none
// ============================================================================
//  Module   : axis_packetizer_v2
//  Purpose  : Gated AXI4-Stream packetizer. Cuts a continuous sample stream
//             into fixed-length packets (cfg_length+1 beats). It marks the
//             first beat with TUSER and the last beat with TLAST. Runs are
//             started by trg_start. A run ends after cfg_packets packets
//             (0 = unlimited) or after a graceful trg_stop.
//  Ports    :
//    aclk, areset                 clock, synchronous active-high reset
//    cfg_length  [CNTR_WIDTH]     beats per packet minus 1 (latched per packet)
//    cfg_packets [PCNT_WIDTH]     packets per run, 0 = unlimited (on start)
//    trg_start / trg_stop         single-cycle run control pulses
//    sts_busy                     RUN state or output register occupied
//    sts_packets [PCNT_WIDTH]     packets completed in current/last run
//    sts_dropped [32]             beats discarded while idle (saturating)
//    s_axis_*                     sample input stream
//    m_axis_*                     packetized output stream (registered)
//  Revision : 1.0 - initial release
// ============================================================================
module axis_packetizer_v2 #(
  parameter int    AXIS_TDATA_WIDTH = 32,
  parameter int    CNTR_WIDTH       = 32,
  parameter int    PCNT_WIDTH       = 16,
  parameter string NON_BLOCKING     = "FALSE"
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic [CNTR_WIDTH-1:0]       cfg_length,
  input  logic [PCNT_WIDTH-1:0]       cfg_packets,
  input  logic                        trg_start,
  input  logic                        trg_stop,
  output logic                        sts_busy,
  output logic [PCNT_WIDTH-1:0]       sts_packets,
  output logic [31:0]                 sts_dropped,
  output logic                        s_axis_tready,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                        s_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid,
  output logic                        m_axis_tlast,
  output logic                        m_axis_tuser
);

  localparam bit C_NB = (NON_BLOCKING == "TRUE");

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                      state_q;
  logic [CNTR_WIDTH-1:0]       beat_cnt_q;
  logic [CNTR_WIDTH-1:0]       len_q;
  logic [PCNT_WIDTH-1:0]       pkt_limit_q;
  logic [PCNT_WIDTH-1:0]       pkt_cnt_q;
  logic                        stop_pend_q;
  logic [31:0]                 dropped_q;
  logic [AXIS_TDATA_WIDTH-1:0] tdata_q;
  logic                        tvalid_q;
  logic                        tlast_q;
  logic                        tuser_q;

  logic                        out_en;
  logic                        run;
  logic                        s_ready;
  logic                        accept;
  logic                        accept_run;
  logic                        is_first;
  logic                        is_last;
  logic [CNTR_WIDTH-1:0]       beat_cnt_d;
  logic [PCNT_WIDTH-1:0]       pkt_cnt_d;
  logic                        limit_hit;
  logic                        end_run;

  // Output register may take a new beat when empty or being drained.
  assign out_en     = ~tvalid_q | m_axis_tready;
  assign run        = (state_q == ST_RUN);
  assign s_ready    = run ? out_en : C_NB;
  assign accept     = s_axis_tvalid & s_ready;
  assign accept_run = accept & run;

  assign is_first   = (beat_cnt_q == '0);
  assign is_last    = (beat_cnt_q >= len_q);
  assign beat_cnt_d = beat_cnt_q + CNTR_WIDTH'(1);
  assign pkt_cnt_d  = pkt_cnt_q + PCNT_WIDTH'(1);
  assign limit_hit  = (pkt_limit_q != '0) && (pkt_cnt_d == pkt_limit_q);
  // A finishing packet ends the run on a pending stop, a stop arriving in
  // the same cycle, or when the programmed packet count is reached.
  assign end_run    = stop_pend_q | trg_stop | limit_hit;

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q     <= ST_IDLE;
      beat_cnt_q  <= '0;
      len_q       <= '0;
      pkt_limit_q <= '0;
      pkt_cnt_q   <= '0;
      stop_pend_q <= 1'b0;
      dropped_q   <= '0;
      tdata_q     <= '0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      tuser_q     <= 1'b0;
    end else begin
      if (out_en) begin
        tvalid_q <= accept_run;
        if (accept_run) begin
          tdata_q <= s_axis_tdata;
          tlast_q <= is_last;
          tuser_q <= is_first;
        end
      end

      case (state_q)
        ST_IDLE: begin
          if (accept && (dropped_q != '1)) begin
            dropped_q <= dropped_q + 32'd1;
          end
          // Start takes priority over a simultaneous stop in idle.
          if (trg_start) begin
            state_q     <= ST_RUN;
            pkt_limit_q <= cfg_packets;
            len_q       <= cfg_length;
            beat_cnt_q  <= '0;
            pkt_cnt_q   <= '0;
            stop_pend_q <= 1'b0;
          end
        end
        ST_RUN: begin
          if (accept && is_last) begin
            beat_cnt_q <= '0;
            len_q      <= cfg_length;
            pkt_cnt_q  <= pkt_cnt_d;
            if (end_run) begin
              state_q     <= ST_IDLE;
              stop_pend_q <= 1'b0;
            end
          end else begin
            if (accept) begin
              beat_cnt_q <= beat_cnt_d;
            end
            if (trg_stop) begin
              stop_pend_q <= 1'b1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign s_axis_tready = s_ready;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tuser  = tuser_q;
  assign sts_busy      = run | tvalid_q;
  assign sts_packets   = pkt_cnt_q;
  assign sts_dropped   = dropped_q;

endmodule
`default_nettype wire
